scale_calc_ctrl: RTL

//  Electronic-scale pricing controller; sits directly upstream of the two-bank 7-seg display driver.

---
 rtl/scale_calc_ctrl_if.sv | 13 +
 rtl/scale_calc_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scale_calc_ctrl_if.sv
// Button inputs and display-side outputs of the scale pricing controller.
interface scale_calc_ctrl_if;
  logic        btn_w, btn_p, btn_ok, btn_mode;
  logic [3:0]  weight, per;
  logic [7:0]  price, times;
  logic [15:0] sum;
  logic        state_cal, busy, sat;

  modport master (output btn_w, btn_p, btn_ok, btn_mode,
                  input  weight, per, price, times, sum, state_cal, busy, sat);
  modport slave  (input  btn_w, btn_p, btn_ok, btn_mode,
                  output weight, per, price, times, sum, state_cal, busy, sat);
endinterface

// File: rtl/scale_calc_ctrl.sv
// Scale pricing controller: button entry, shift-add price multiply, total/count accumulation.
// Optional SCALE_SAT_EN: sum/times clamp instead of wrapping and a sticky sat flag is raised.
module scale_calc_ctrl #(
  parameter int W_MAX     = 15,
  parameter int P_MAX     = 15,
  parameter int SUM_MOD   = 10000,
  parameter int TIMES_MOD = 100
) (
  input  logic clk,
  input  logic state_reset,
  scale_calc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_EDIT, ST_MUL, ST_ACC, ST_SHOW} state_t;

  localparam logic [3:0]  W_TOP = 4'(W_MAX);
  localparam logic [3:0]  P_TOP = 4'(P_MAX);
  localparam logic [15:0] S_MOD = 16'(SUM_MOD);
  localparam logic [7:0]  T_TOP = 8'(TIMES_MOD - 1);

  // bit order everywhere: {mode, ok, p, w}
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d, edge_q, edge_d;
  state_t     state_q, state_d;
  logic [3:0] weight_q, weight_d, per_q, per_d, mplier_q, mplier_d;
  logic [7:0] price_q, price_d, times_q, times_d, mcand_q, mcand_d, acc_q, acc_d, acc_nx;
  logic [15:0] sum_q, sum_d, sum_nx;
  logic [2:0] cnt_q, cnt_d;
  logic       state_cal_q, state_cal_d;
  logic       e_w, e_p, e_ok, e_mode;
`ifdef SCALE_SAT_EN
  logic       sat_q, sat_d;
`endif

  assign {e_mode, e_ok, e_p, e_w} = edge_q;

  always_comb begin
    sync1_d     = {bus.btn_mode, bus.btn_ok, bus.btn_p, bus.btn_w};
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    edge_d      = sync2_q & ~hist_q;
    state_d     = state_q;
    weight_d    = weight_q;
    per_d       = per_q;
    price_d     = price_q;
    times_d     = times_q;
    sum_d       = sum_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_nx      = acc_q + (mplier_q[0] ? mcand_q : 8'd0);
    sum_nx      = sum_q + {8'd0, price_q};
`ifdef SCALE_SAT_EN
    sat_d       = sat_q;
`endif
    unique case (state_q)
      ST_EDIT: begin
        // btn_ok owns the cycle even when it is ignored for a zero price
        if (e_ok) begin
          if (price_q != 8'd0) state_d = ST_ACC;
        end else if (e_mode) begin
          state_d = ST_SHOW;
        end else if (e_w || e_p) begin
          if (e_w) weight_d = (weight_q == W_TOP) ? 4'd0 : weight_q + 4'd1;
          if (e_p) per_d    = (per_q == P_TOP) ? 4'd0 : per_q + 4'd1;
          cnt_d   = 3'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == 3'd0) begin
          acc_d    = 8'd0;
          mcand_d  = {4'd0, weight_q};
          mplier_d = per_q;
          cnt_d    = 3'd1;
        end else begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd4) begin
            price_d = acc_nx;
            state_d = ST_EDIT;
          end
        end
      end
      ST_ACC: begin
`ifdef SCALE_SAT_EN
        if (sum_nx >= S_MOD) begin
          sum_d = S_MOD - 16'd1;
          sat_d = 1'b1;
        end else begin
          sum_d = sum_nx;
        end
        if (times_q == T_TOP) sat_d = 1'b1;
        else                  times_d = times_q + 8'd1;
`else
        // price < SUM_MOD, so one subtract is a full modulo
        sum_d   = (sum_nx >= S_MOD) ? sum_nx - S_MOD : sum_nx;
        times_d = (times_q == T_TOP) ? 8'd0 : times_q + 8'd1;
`endif
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (e_ok) begin
          weight_d = 4'd0;
          per_d    = 4'd0;
          price_d  = 8'd0;
          state_d  = ST_EDIT;
        end else if (e_mode) begin
          state_d = ST_EDIT;
        end
      end
      default: state_d = ST_EDIT;
    endcase
    state_cal_d = (state_d == ST_SHOW);
  end

  always_ff @(posedge clk) begin
    if (state_reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      edge_q      <= '0;
      state_q     <= ST_EDIT;
      weight_q    <= '0;
      per_q       <= '0;
      price_q     <= '0;
      times_q     <= '0;
      sum_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      state_cal_q <= 1'b0;
`ifdef SCALE_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      edge_q      <= edge_d;
      state_q     <= state_d;
      weight_q    <= weight_d;
      per_q       <= per_d;
      price_q     <= price_d;
      times_q     <= times_d;
      sum_q       <= sum_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      state_cal_q <= state_cal_d;
`ifdef SCALE_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign bus.weight    = weight_q;
  assign bus.per       = per_q;
  assign bus.price     = price_q;
  assign bus.times     = times_q;
  assign bus.sum       = sum_q;
  assign bus.state_cal = state_cal_q;
  assign bus.busy      = (state_q == ST_MUL);
`ifdef SCALE_SAT_EN
  assign bus.sat       = sat_q;
`else
  assign bus.sat       = 1'b0;
`endif
endmodule
